// File: rtl/mem_bus_arbiter_if.sv
// Shared-memory bus between the two cache controllers, the arbiter and memory.
// slave = arbiter view; master = requesters plus memory.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          HRequestM;
  logic          HWriteM;
  logic [AW-1:0] HAddrM;
  logic [DW-1:0] HWDataM;
  logic          HRequestI;
  logic [AW-1:0] HAddrI;
  logic          MemReady;
  logic [DW-1:0] MemRData;
  logic          MemEn;
  logic          MemWE;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] HRData;
  logic          BusReadyM;
  logic          BusReadyI;
  logic          GrantM;
  logic          GrantI;

  modport slave (
    input  HRequestM, HWriteM, HAddrM, HWDataM, HRequestI, HAddrI,
           MemReady, MemRData,
    output MemEn, MemWE, MemAddr, MemWData, HRData,
           BusReadyM, BusReadyI, GrantM, GrantI
  );

  modport master (
    output HRequestM, HWriteM, HAddrM, HWDataM, HRequestI, HAddrI,
           MemReady, MemRData,
    input  MemEn, MemWE, MemAddr, MemWData, HRData,
           BusReadyM, BusReadyI, GrantM, GrantI
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master block-transfer arbiter onto one memory port: one IDLE cycle between
// blocks, ties broken against the previous owner, beats passed through combinationally.
module mem_bus_arbiter #(
  parameter int BEATS = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, OWN_M, OWN_I} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          last_q, last_d;   // 1 = data side owned the previous block

  logic          grant_m, grant_i, req, beat;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    last_d    = last_q;
    grant_m   = 1'b0;
    grant_i   = 1'b0;
    req       = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.HRequestM && (!bus.HRequestI || !last_q)) begin
          state_d = OWN_M;
          wr_d    = bus.HWriteM;
        end else if (bus.HRequestI) begin
          state_d = OWN_I;
          wr_d    = 1'b0;
        end
      end
      OWN_M: begin
        grant_m   = 1'b1;
        req       = bus.HRequestM;
        addr_mux  = bus.HAddrM;
        wdata_mux = bus.HWDataM;
      end
      OWN_I: begin
        grant_i  = 1'b1;
        req      = bus.HRequestI;
        addr_mux = bus.HAddrI;
      end
      default: state_d = IDLE;
    endcase

    beat = req & bus.MemReady;
    // A dropped request aborts the block without touching the fairness bit.
    if (state_q != IDLE) begin
      if (!req) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (beat) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          last_d  = grant_m;
        end
      end
    end
  end

  assign bus.GrantM    = grant_m;
  assign bus.GrantI    = grant_i;
  assign bus.MemEn     = req;
  assign bus.MemWE     = wr_q & req;
  assign bus.MemAddr   = addr_mux;
  assign bus.MemWData  = wdata_mux;
  assign bus.HRData    = bus.MemRData;
  assign bus.BusReadyM = grant_m & beat;
  assign bus.BusReadyI = grant_i & beat;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a block-level ownership model checked every
// cycle, plus hand-computed beat counts and block logs for each scenario.
module tb_mem_bus_arbiter;
  localparam int BEATS = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.BEATS(BEATS), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 data, 2 instr), beats done in the block,
  // direction of the block, who finished last, and a log of completed blocks
  // encoded as side*2+write (data read=2, data write=3, instr=4).
  int owner  = 0;
  int beats  = 0;
  bit dir    = 1'b0;
  bit last_m = 1'b0;
  int blog[$];

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      owner = 0; beats = 0; dir = 1'b0; last_m = 1'b0;
    end else if (owner == 0) begin
      beats = 0;
      if (bus.HRequestM && (!bus.HRequestI || !last_m)) begin
        owner = 1; dir = bus.HWriteM;
      end else if (bus.HRequestI) begin
        owner = 2; dir = 1'b0;
      end
    end else if (!(owner == 1 ? bus.HRequestM : bus.HRequestI)) begin
      owner = 0;
    end else if (bus.MemReady) begin
      beats++;
      if (beats == BEATS) begin
        blog.push_back(owner * 2 + int'(dir));
        last_m = (owner == 1);
        owner  = 0;
      end
    end
  end

  int obs_brm = 0, obs_bri = 0, obs_we = 0;
  logic          e_en;
  logic [5:0]    e_ctl;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  initial forever begin
    @(negedge clk);
    e_en   = (owner == 1 && bus.HRequestM) || (owner == 2 && bus.HRequestI);
    e_ctl  = {owner == 1, owner == 2, e_en, owner == 1 && dir && e_en,
              owner == 1 && e_en && bus.MemReady, owner == 2 && e_en && bus.MemReady};
    e_addr = (owner == 1) ? bus.HAddrM : (owner == 2) ? bus.HAddrI : '0;
    e_wd   = (owner == 1) ? bus.HWDataM : '0;
    chk("ctl{gm,gi,en,we,brm,bri}",
        64'({bus.GrantM, bus.GrantI, bus.MemEn, bus.MemWE, bus.BusReadyM, bus.BusReadyI}),
        64'(e_ctl));
    chk("MemAddr", 64'(bus.MemAddr), 64'(e_addr));
    chk("MemWData", 64'(bus.MemWData), 64'(e_wd));
    chk("HRData", 64'(bus.HRData), 64'(bus.MemRData));
    chk("grant overlap", 64'(bus.GrantM & bus.GrantI), 64'd0);
    if (bus.BusReadyM) obs_brm++;
    if (bus.BusReadyI) obs_bri++;
    if (bus.MemWE)     obs_we++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    obs_brm = 0; obs_bri = 0; obs_we = 0;
  endtask

  logic [7:0] pat = 8'b10110100;  // applied LSB first: 0,0,1,0,1,1,0,1
  int n;

  initial begin
    bus.HRequestM = 1'b0; bus.HWriteM = 1'b0; bus.HAddrM = '0; bus.HWDataM = '0;
    bus.HRequestI = 1'b0; bus.HAddrI = '0; bus.MemReady = 1'b0; bus.MemRData = '0;
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("reset GrantM", 64'(bus.GrantM), 64'd0);
    chk("reset MemEn", 64'(bus.MemEn), 64'd0);

    // Single refill with MemReady always high
    tick();
    bus.HRequestM = 1'b1; bus.HWriteM = 1'b0; bus.MemReady = 1'b1;
    bus.HAddrM = 32'h1000; bus.HWDataM = 32'hAAAA0001; bus.MemRData = 32'h5555_0001;
    bus.HAddrI = 32'h2000;
    clr_obs();
    repeat (5) tick();
    bus.HRequestM = 1'b0;
    chk("T1 beats", 64'(obs_brm), 64'd4);
    chk("T1 no write", 64'(obs_we), 64'd0);
    chk("T1 block log", 64'(blog[$]), 64'd2);
    @(negedge clk);
    chk("T1 idle after block", 64'(bus.GrantM), 64'd0);
    tick();

    // Writeback then refill, HRequestM held; mid-block HWriteM flip is ignored
    bus.HRequestM = 1'b1; bus.HWriteM = 1'b1; bus.HAddrM = 32'h1100;
    clr_obs();
    tick();
    bus.HWriteM = 1'b0;
    repeat (9) tick();
    bus.HRequestM = 1'b0;
    chk("T2 beats", 64'(obs_brm), 64'd8);
    chk("T2 write beats", 64'(obs_we), 64'd4);
    chk("T2 log wb", 64'(blog[blog.size()-2]), 64'd3);
    chk("T2 log refill", 64'(blog[blog.size()-1]), 64'd2);
    tick();

    // Tie from reset: M, I, M
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.HRequestM = 1'b1; bus.HRequestI = 1'b1; bus.HWriteM = 1'b0;
    clr_obs();
    n = blog.size();
    repeat (15) tick();
    bus.HRequestM = 1'b0; bus.HRequestI = 1'b0;
    chk("T3 M beats", 64'(obs_brm), 64'd8);
    chk("T3 I beats", 64'(obs_bri), 64'd4);
    chk("T3 blocks", 64'(blog.size() - n), 64'd3);
    chk("T3 first M", 64'(blog[n]), 64'd2);
    chk("T3 then I", 64'(blog[n+1]), 64'd4);
    chk("T3 then M", 64'(blog[n+2]), 64'd2);
    repeat (2) tick();

    // Instruction refill with wait states
    bus.HRequestI = 1'b1; bus.MemReady = 1'b0; bus.HAddrI = 32'h2040;
    clr_obs();
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.MemReady = pat[i];
      @(negedge clk);
      chk("T4 addr stable", 64'(bus.MemAddr), 64'h2040);
      tick();
    end
    bus.HRequestI = 1'b0; bus.MemReady = 1'b0;
    chk("T4 beats", 64'(obs_bri), 64'd4);
    @(negedge clk);
    chk("T4 idle after 4th", 64'(bus.GrantI), 64'd0);
    tick();

    // Abort after two beats, then a fresh block needs all four
    bus.HRequestM = 1'b1; bus.HWriteM = 1'b0; bus.MemReady = 1'b1; bus.HAddrM = 32'h3000;
    clr_obs();
    repeat (3) tick();
    bus.HRequestM = 1'b0;
    @(negedge clk);
    chk("T5 abort MemEn", 64'(bus.MemEn), 64'd0);
    chk("T5 abort still granted", 64'(bus.GrantM), 64'd1);
    tick();
    chk("T5 beats before abort", 64'(obs_brm), 64'd2);
    @(negedge clk);
    chk("T5 idle after abort", 64'(bus.GrantM), 64'd0);
    bus.HRequestM = 1'b1;
    clr_obs();
    repeat (5) tick();
    bus.HRequestM = 1'b0;
    chk("T5 restart beats", 64'(obs_brm), 64'd4);
    @(negedge clk);
    chk("T5 idle after restart", 64'(bus.GrantM), 64'd0);
    tick();

    // Asynchronous reset in the middle of a beat
    bus.HRequestM = 1'b1; bus.MemReady = 1'b0; bus.HAddrM = 32'h4000;
    tick();
    tick();
    bus.MemReady = 1'b1;
    #1;
    chk("T6 pre-reset MemEn", 64'(bus.MemEn), 64'd1);
    chk("T6 pre-reset BusReadyM", 64'(bus.BusReadyM), 64'd1);
    reset = 1'b0;
    #1;
    chk("T6 reset MemEn", 64'(bus.MemEn), 64'd0);
    chk("T6 reset GrantM", 64'(bus.GrantM), 64'd0);
    chk("T6 reset BusReadyM", 64'(bus.BusReadyM), 64'd0);
    tick();
    reset = 1'b1;
    bus.HRequestI = 1'b1;
    @(negedge clk);
    chk("T6 idle after release", 64'(bus.GrantM), 64'd0);
    tick();
    @(negedge clk);
    chk("T6 tie GrantM", 64'(bus.GrantM), 64'd1);
    chk("T6 tie GrantI", 64'(bus.GrantI), 64'd0);
    bus.HRequestM = 1'b0; bus.HRequestI = 1'b0; bus.MemReady = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
